// File: rtl/emoji_pkg.sv
// Constants shared by the scheduler, the frame-tick helper and the emoji
// colour modules: frame encodings, emoji IDs, 640x480@60 timing and colours.
package emoji_pkg;

    // Animation frame encodings carried on o_frame
    localparam logic [1:0] FRAME_1 = 2'd0;
    localparam logic [1:0] FRAME_2 = 2'd1;
    localparam logic [1:0] FRAME_3 = 2'd2;
    localparam logic [1:0] FRAME_4 = 2'd3;

    // Emoji animations in rotation order
    typedef enum logic [1:0] {
        EMOJI_MAD   = 2'd0,
        EMOJI_HAPPY = 2'd1,
        EMOJI_SAD   = 2'd2,
        EMOJI_COOL  = 2'd3
    } emoji_id_e;

    // Last counter values for 640x480@60 (800x525 total)
    localparam int H_LAST_VGA = 799;
    localparam int V_LAST_VGA = 524;

    // Scheduler states
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_PAUSED = 1'b1;

    // RGB444 colours shared with the emoji modules
    localparam logic [11:0] COLOUR_BLACK  = 12'h000;
    localparam logic [11:0] COLOUR_WHITE  = 12'hFFF;
    localparam logic [11:0] COLOUR_YELLOW = 12'hFD0;
    localparam logic [11:0] COLOUR_RED    = 12'hF00;
    localparam logic [11:0] COLOUR_BLUE   = 12'h05F;
    localparam logic [11:0] COLOUR_BROWN  = 12'h840;

endpackage

// File: rtl/emoji_scheduler_frame_tick.sv
// Detects the last pixel of a screen (eof) and registers it into a pulse
// that lines up with pixel (0,0) of the next screen.
module frame_tick
    import emoji_pkg::*;
#(
    parameter int H_LAST = H_LAST_VGA,
    parameter int V_LAST = V_LAST_VGA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_hcounter,
    input  logic [9:0] i_vcounter,
    output logic       o_eof,
    output logic       o_frame_start
);

    logic frame_start_d;
    logic frame_start_q;

    // End-of-screen detect and next value of the start pulse
    always_comb begin
        o_eof         = (i_hcounter == 10'(H_LAST)) && (i_vcounter == 10'(V_LAST));
        frame_start_d = o_eof;
    end

    // Start pulse register, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign o_frame_start = frame_start_q;

endmodule

// File: rtl/emoji_scheduler.sv
// Sequences emoji animations: picks the active emoji and its animation frame,
// counting whole video frames and changing only at the end-of-screen boundary.
module emoji_scheduler
    import emoji_pkg::*;
#(
    parameter int N_EMOJI = 4,
    parameter int HOLD_F1 = 30,
    parameter int HOLD_F2 = 6,
    parameter int HOLD_F3 = 6,
    parameter int HOLD_F4 = 90,
    parameter int LOOPS   = 3,
    parameter int H_LAST  = H_LAST_VGA,
    parameter int V_LAST  = V_LAST_VGA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_hcounter,
    input  logic [9:0] i_vcounter,
    input  logic       i_next,
    input  logic       i_pause,
    output logic [1:0] o_emoji_sel,
    output logic [1:0] o_frame,
    output logic       o_frame_start,
    output logic       o_paused
);

    logic       eof;

    logic [0:0] state_d,     state_q;
    logic [1:0] frame_d,     frame_q;
    logic [1:0] emoji_sel_d, emoji_sel_q;
    logic [7:0] hold_cnt_d,  hold_cnt_q;
    logic [3:0] loop_cnt_d,  loop_cnt_q;
    logic       next_pend_d, next_pend_q;

    // Last hold count value for the given frame
    function automatic logic [7:0] hold_last(input logic [1:0] frame);
        case (frame)
            FRAME_1: hold_last = 8'(HOLD_F1 - 1);
            FRAME_2: hold_last = 8'(HOLD_F2 - 1);
            FRAME_3: hold_last = 8'(HOLD_F3 - 1);
            default: hold_last = 8'(HOLD_F4 - 1);
        endcase
    endfunction

    // Next emoji in rotation, wrapping after the last one
    function automatic logic [1:0] next_emoji(input logic [1:0] sel);
        if (sel == 2'(N_EMOJI - 1)) begin
            next_emoji = 2'd0;
        end else begin
            next_emoji = sel + 2'd1;
        end
    endfunction

    frame_tick #(
        .H_LAST (H_LAST),
        .V_LAST (V_LAST)
    ) u_frame_tick (
        .clk           (clk),
        .rst           (rst),
        .i_hcounter    (i_hcounter),
        .i_vcounter    (i_vcounter),
        .o_eof         (eof),
        .o_frame_start (o_frame_start)
    );

    // Skip latch, animation counters and pause FSM, all updated only at eof
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        emoji_sel_d = emoji_sel_q;
        hold_cnt_d  = hold_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        // Any number of requests within one screen collapse into one skip
        next_pend_d = next_pend_q | i_next;

        if (eof) begin
            next_pend_d = 1'b0;
            if (next_pend_q || i_next) begin
                // Skip beats both pause and a coincident natural advance
                emoji_sel_d = next_emoji(emoji_sel_q);
                frame_d     = FRAME_1;
                hold_cnt_d  = 8'd0;
                loop_cnt_d  = 4'd0;
            end else if (state_q == ST_RUN) begin
                if (hold_cnt_q == hold_last(frame_q)) begin
                    hold_cnt_d = 8'd0;
                    if (frame_q == FRAME_4) begin
                        frame_d = FRAME_1;
                        if (loop_cnt_q == 4'(LOOPS - 1)) begin
                            loop_cnt_d  = 4'd0;
                            emoji_sel_d = next_emoji(emoji_sel_q);
                        end else begin
                            loop_cnt_d = loop_cnt_q + 4'd1;
                        end
                    end else begin
                        frame_d = frame_q + 2'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            state_d = i_pause ? ST_PAUSED : ST_RUN;
        end
    end

    // State registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            frame_q     <= FRAME_1;
            emoji_sel_q <= 2'd0;
            hold_cnt_q  <= 8'd0;
            loop_cnt_q  <= 4'd0;
            next_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            emoji_sel_q <= emoji_sel_d;
            hold_cnt_q  <= hold_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            next_pend_q <= next_pend_d;
        end
    end

    assign o_frame     = frame_q;
    assign o_emoji_sel = emoji_sel_q;
    assign o_paused    = (state_q == ST_PAUSED);

endmodule

// File: tb/tb_emoji_scheduler.sv
// Directed bench for emoji_scheduler with a tiny 8x4 screen so animations
// run in a few hundred cycles.
module tb_emoji_scheduler;

    localparam int HL = 7;
    localparam int VL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] i_hcounter = 10'd0;
    logic [9:0] i_vcounter = 10'd0;
    logic       i_next = 1'b0;
    logic       i_pause = 1'b0;
    logic [1:0] o_emoji_sel;
    logic [1:0] o_frame;
    logic       o_frame_start;
    logic       o_paused;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_f = 0;
    int exp_s = 0;
    int exp_p = 0;
    bit was_eof;

    // Frame shown after the k-th eof of a loop (HOLD 2,1,1,3)
    int pat [7]  = '{0, 1, 2, 3, 3, 3, 0};
    // Frames from FRAME_2/hold 0/loop 0 up to the eof before the loop wrap
    int coll [11] = '{2, 3, 3, 3, 0, 0, 1, 2, 3, 3, 3};

    emoji_scheduler #(
        .N_EMOJI (3),
        .HOLD_F1 (2),
        .HOLD_F2 (1),
        .HOLD_F3 (1),
        .HOLD_F4 (3),
        .LOOPS   (2),
        .H_LAST  (HL),
        .V_LAST  (VL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_hcounter    (i_hcounter),
        .i_vcounter    (i_vcounter),
        .i_next        (i_next),
        .i_pause       (i_pause),
        .o_emoji_sel   (o_emoji_sel),
        .o_frame       (o_frame),
        .o_frame_start (o_frame_start),
        .o_paused      (o_paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // One clock: sample just after the edge, then move the pixel counters on
    task automatic tick();
        @(posedge clk);
        #1;
        was_eof = (i_hcounter == 10'(HL)) && (i_vcounter == 10'(VL));
        if (i_hcounter == 10'(HL)) begin
            i_hcounter = 10'd0;
            i_vcounter = (i_vcounter == 10'(VL)) ? 10'd0 : i_vcounter + 10'd1;
        end else begin
            i_hcounter = i_hcounter + 10'd1;
        end
    endtask

    // Run until an eof edge; outputs must hold the expected values meanwhile
    task automatic screen(input string tag, input int n_pulses, input bit at_eof);
        int unstable = 0;
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (was_eof) begin
                done = 1'b1;
            end else begin
                if (o_frame != 2'(exp_f) || o_emoji_sel != 2'(exp_s) ||
                    o_paused != 1'(exp_p) || o_frame_start != 1'b0)
                    unstable++;
                i_next = (n_pulses >= 1 && i == 17) || (n_pulses >= 2 && i == 19) ||
                         (n_pulses >= 3 && i == 21) ||
                         (at_eof && i_hcounter == 10'(HL) && i_vcounter == 10'(VL));
            end
        end
        i_next = 1'b0;
        chk({tag, " steady"}, unstable, 0);
        chk({tag, " eof_seen"}, int'(done), 1);
    endtask

    // Expected outputs right after an eof edge
    task automatic expect_out(input string tag, input int f, input int s, input int p);
        exp_f = f;
        exp_s = s;
        exp_p = p;
        chk({tag, " frame_start"}, int'(o_frame_start), 1);
        chk({tag, " frame"},       int'(o_frame), f);
        chk({tag, " emoji_sel"},   int'(o_emoji_sel), s);
        chk({tag, " paused"},      int'(o_paused), p);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst frame", int'(o_frame), 0);
        chk("rst sel", int'(o_emoji_sel), 0);
        chk("rst start", int'(o_frame_start), 0);
        chk("rst paused", int'(o_paused), 0);
        rst = 1'b0;

        // Natural sequence and emoji rotation over three emojis
        for (int k = 1; k <= 44; k++) begin
            screen("run", 0, 1'b0);
            expect_out("run", pat[(k - 1) % 7], (k / 14) % 3, 0);
        end

        // Asynchronous reset mid-screen, no clock edge in between
        repeat (5) tick();
        rst = 1'b1;
        #2;
        chk("async frame", int'(o_frame), 0);
        chk("async sel", int'(o_emoji_sel), 0);
        chk("async start", int'(o_frame_start), 0);
        chk("async paused", int'(o_paused), 0);
        tick();
        rst = 1'b0;
        exp_f = 0; exp_s = 0; exp_p = 0;
        screen("post_rst1", 0, 1'b0);
        expect_out("post_rst1", 0, 0, 0);
        screen("post_rst2", 0, 1'b0);
        expect_out("post_rst2", 1, 0, 0);
        screen("post_rst3", 0, 1'b0);
        expect_out("post_rst3", 2, 0, 0);

        // Skip mid-screen, then three pulses in one screen
        screen("skip1", 1, 1'b0);
        expect_out("skip1", 0, 1, 0);
        screen("skip3", 3, 1'b0);
        expect_out("skip3", 0, 2, 0);
        screen("skip_hold1", 0, 1'b0);
        expect_out("skip_hold1", 0, 2, 0);
        screen("skip_hold2", 0, 1'b0);
        expect_out("skip_hold2", 1, 2, 0);

        // Pause: last advance at the pausing eof, then frozen
        i_pause = 1'b1;
        screen("pause_in", 0, 1'b0);
        expect_out("pause_in", 2, 2, 1);
        for (int k = 0; k < 9; k++) begin
            screen("paused", 0, 1'b0);
            expect_out("paused", 2, 2, 1);
        end
        screen("pause_skip", 1, 1'b0);
        expect_out("pause_skip", 0, 0, 1);
        i_pause = 1'b0;
        screen("resume", 0, 1'b0);
        expect_out("resume", 0, 0, 0);
        screen("resume_h1", 0, 1'b0);
        expect_out("resume_h1", 0, 0, 0);
        screen("resume_h2", 0, 1'b0);
        expect_out("resume_h2", 1, 0, 0);

        // Walk to the eof where the loop wrap would advance the emoji
        for (int k = 0; k < 11; k++) begin
            screen("to_wrap", 0, 1'b0);
            expect_out("to_wrap", coll[k], 0, 0);
        end
        screen("collide", 0, 1'b1);
        expect_out("collide", 0, 1, 0);
        for (int k = 1; k <= 14; k++) begin
            screen("after_collide", 0, 1'b0);
            expect_out("after_collide", pat[(k - 1) % 7], (k == 14) ? 2 : 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
